multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle successor to the single-cycle control signal generator for the P4 MIPS-subset CPU. A state machine sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and decodes opcode/funct internally. It handshakes with instruction and data memories that have variable latency and an optional timeout. It drives the same datapath mux selects as the single-cycle design, plus PC/IR write enables, and adds a retired-instruction counter and sticky trap flags.

## Interface
- ACK_TIMEOUT, 16: max cycles a memory request may wait for ack before trap; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  Instr[31:26] from IR
- funct  in  6  Instr[5:0] from IR
- alu_zero  in  1  ALU zero flag
- imem_ack  in  1  instruction word valid this cycle
- dmem_ack  in  1  data access complete this cycle
- imem_req, dmem_req, dmem_we  out  1  memory request strobes
- ir_we, pc_we, grf_we  out  1  IR, PC, register-file write enables
- wa_ctrl  out  2  00 rt, 01 rd, 10 $31
- wd_ctrl  out  2  00 ALU, 01 DM, 10 PC+4
- alu_ctrl  out  2  00 add, 01 sub, 10 or, 11 B<<16
- alub_ctrl  out  1  0 RD2, 1 EXT
- ext_ctrl  out  1  0 zero, 1 sign
- jump_ctrl  out  2  00 PC+4, 01 branch target, 10 jal target, 11 RD1
- state  out  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5
- illegal, bus_err  out  1  sticky trap causes
- retired  out  CNT_W  instructions retired, wraps modulo 2^CNT_W

## Operation
- Decode: opcode 000000 with funct 100001 is addu, 100011 is subu, 001000 is jr, and 000000 is nop. Opcode 001101 is ori, 100011 lw, 101011 sw, 000100 beq, 001111 lui, 000011 jal. Every other opcode/funct combination is illegal.
- All control outputs are combinational from state, the decoded class and the ack inputs. Any output not listed for a state is 0.
- FETCH: imem_req=1. When imem_ack=1, ir_we=1 and the next state is DECODE.
- DECODE: ext_ctrl per instruction (sign for lw/sw/beq, zero otherwise).
  - nop: pc_we=1, jump_ctrl=00, next FETCH.
  - illegal: next TRAP, illegal<=1.
  - anything else: next EXEC.
- EXEC: alu_ctrl, alub_ctrl and ext_ctrl are held per instruction:
  - addu: add/RD2. subu: sub/RD2. ori: or/EXT/zero. lui: shl16/EXT/zero. lw/sw: add/EXT/sign. beq: sub/RD2.
  - addu, subu, ori, lui go to WB. lw and sw go to MEM.
  - beq: pc_we=1, jump_ctrl={0,alu_zero}, next FETCH.
  - jal: grf_we=1, wa_ctrl=10, wd_ctrl=10, pc_we=1, jump_ctrl=10, next FETCH.
  - jr: pc_we=1, jump_ctrl=11, next FETCH.
- MEM: dmem_req=1, dmem_we=1 for sw only, and the EXEC ALU selects are held. When dmem_ack=1:
  - sw: pc_we=1, next FETCH.
  - lw: next WB.
- WB: grf_we=1, pc_we=1, jump_ctrl=00, next FETCH. ALU selects are held.
  - addu/subu: wa_ctrl=01, wd_ctrl=00.
  - ori/lui: wa_ctrl=00, wd_ctrl=00.
  - lw: wa_ctrl=00, wd_ctrl=01.
- TRAP: absorbing. All strobes and enables are 0. Only reset exits it.
- retired increments by 1 on every cycle with pc_we=1, wrapping from all-ones to 0.

## Timing
- Reset values: state=FETCH, illegal=0, bus_err=0, retired=0, wait counter=0. In the first cycle after reset, outputs take FETCH values: imem_req=1 and all other outputs 0.
- Reset asserted in any state, including mid-MEM or TRAP, forces the reset values on the next edge. Pending requests are dropped.
- Latency with ack in the same cycle as the request:
  - nop: 2 cycles.
  - beq, jal, jr: 3 cycles.
  - addu, subu, ori, lui, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- Request strobes stay high continuously until ack. An ack outside the matching wait state is ignored.
- Wait counter:
  - Clears on entry to FETCH or MEM and on ack.
  - Increments on each request cycle without ack.
  - If ACK_TIMEOUT>0 and the counter equals ACK_TIMEOUT-1 in a cycle without ack, the next state is TRAP and bus_err<=1.
  - An ack in that same cycle wins and no trap occurs.
- pc_we is a single-cycle pulse, exactly once per retired instruction. Trapped instructions do not retire.

## Test plan
- Reset, then addu with imem_ack and dmem_ack tied high. Required: state 0,1,2,4,0; grf_we=1 only in WB, with wa_ctrl=01 and wd_ctrl=00; retired=1 after 4 cycles.
- lw with dmem_ack delayed 3 cycles. Required: dmem_req high for 4 consecutive cycles; wd_ctrl=01 in WB; total 8 cycles; bus_err=0.
- beq with alu_zero=1, then with alu_zero=0. Required: jump_ctrl=01 and then 00 in EXEC; pc_we pulses once each; 3 cycles each.
- opcode=111111. Required: TRAP after DECODE; illegal=1; all enables 0 for 10 further cycles; retired unchanged.
- ACK_TIMEOUT=4 with imem_ack held low. Required: TRAP entered 4 cycles after entering FETCH; bus_err=1. Repeat with ack on the 4th cycle. Required: no trap.
- CNT_W=4 with 16 nop instructions. Required: retired wraps 15→0. Then assert reset during MEM of an sw. Required: state=FETCH, retired=0, no pc_we.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and the datapath and memories.
// The master side is the controller; the slave side is the datapath/memory environment.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             imem_ack;
  logic             dmem_ack;

  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_we;
  logic             pc_we;
  logic             grf_we;
  logic [1:0]       wa_ctrl;
  logic [1:0]       wd_ctrl;
  logic [1:0]       alu_ctrl;
  logic             alub_ctrl;
  logic             ext_ctrl;
  logic [1:0]       jump_ctrl;
  logic [2:0]       state;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, alu_zero, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, grf_we, wa_ctrl, wd_ctrl, alu_ctrl,
           alub_ctrl, ext_ctrl, jump_ctrl, state, illegal, bus_err, retired
  );

  modport slave (
    output opcode, funct, alu_zero, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, grf_we, wa_ctrl, wd_ctrl, alu_ctrl,
           alub_ctrl, ext_ctrl, jump_ctrl, state, illegal, bus_err, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the MIPS-subset CPU: sequences FETCH/DECODE/EXEC/MEM/WB,
// handshakes with variable-latency memories, counts retired instructions and latches traps.
module multicycle_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    InsNop, InsAddu, InsSubu, InsJr, InsOri, InsLw, InsSw, InsBeq, InsLui, InsJal, InsIllegal
  } ins_e;

  localparam int unsigned      WaitW    = $clog2(ACK_TIMEOUT + 1) + 1;
  localparam logic [WaitW-1:0] WaitLast = (ACK_TIMEOUT == 0) ? '0 : WaitW'(ACK_TIMEOUT - 1);
  localparam bit               TimeoutEn = (ACK_TIMEOUT != 0);

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               illegal_q, bus_err_q;
  logic [CNT_W-1:0]   retired_q;
  logic               set_illegal, set_bus_err;
  logic               req_wait;
  ins_e               ins;

  logic       ins_alub, ins_ext;
  logic [1:0] ins_alu;

  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, grf_we;
  logic [1:0] wa_ctrl, wd_ctrl, alu_ctrl, jump_ctrl;
  logic       alub_ctrl, ext_ctrl;

  // Instruction class decode from the IR fields.
  always_comb begin
    ins = InsIllegal;
    case (bus.opcode)
      6'b000000: begin
        case (bus.funct)
          6'b100001: ins = InsAddu;
          6'b100011: ins = InsSubu;
          6'b001000: ins = InsJr;
          6'b000000: ins = InsNop;
          default:   ins = InsIllegal;
        endcase
      end
      6'b001101: ins = InsOri;
      6'b100011: ins = InsLw;
      6'b101011: ins = InsSw;
      6'b000100: ins = InsBeq;
      6'b001111: ins = InsLui;
      6'b000011: ins = InsJal;
      default:   ins = InsIllegal;
    endcase
  end

  // ALU operand/operation selects, held from EXEC through MEM and WB.
  always_comb begin
    ins_alu  = 2'b00;
    ins_alub = 1'b0;
    ins_ext  = 1'b0;
    case (ins)
      InsSubu, InsBeq: ins_alu = 2'b01;
      InsOri: begin
        ins_alu  = 2'b10;
        ins_alub = 1'b1;
      end
      InsLui: begin
        ins_alu  = 2'b11;
        ins_alub = 1'b1;
      end
      InsLw, InsSw: begin
        ins_alub = 1'b1;
        ins_ext  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    grf_we      = 1'b0;
    wa_ctrl     = 2'b00;
    wd_ctrl     = 2'b00;
    alu_ctrl    = 2'b00;
    alub_ctrl   = 1'b0;
    ext_ctrl    = 1'b0;
    jump_ctrl   = 2'b00;
    state_d     = state_q;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    req_wait    = 1'b0;

    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else begin
          req_wait = 1'b1;
        end
      end

      StDecode: begin
        ext_ctrl = ins inside {InsLw, InsSw, InsBeq};
        if (ins == InsNop) begin
          pc_we   = 1'b1;
          state_d = StFetch;
        end else if (ins == InsIllegal) begin
          set_illegal = 1'b1;
          state_d     = StTrap;
        end else begin
          state_d = StExec;
        end
      end

      StExec: begin
        alu_ctrl  = ins_alu;
        alub_ctrl = ins_alub;
        ext_ctrl  = ins_ext;
        case (ins)
          InsLw, InsSw: state_d = StMem;
          InsBeq: begin
            pc_we     = 1'b1;
            jump_ctrl = {1'b0, bus.alu_zero};
            state_d   = StFetch;
          end
          InsJal: begin
            grf_we    = 1'b1;
            wa_ctrl   = 2'b10;
            wd_ctrl   = 2'b10;
            pc_we     = 1'b1;
            jump_ctrl = 2'b10;
            state_d   = StFetch;
          end
          InsJr: begin
            pc_we     = 1'b1;
            jump_ctrl = 2'b11;
            state_d   = StFetch;
          end
          default: state_d = StWb;
        endcase
      end

      StMem: begin
        alu_ctrl  = ins_alu;
        alub_ctrl = ins_alub;
        ext_ctrl  = ins_ext;
        dmem_req  = 1'b1;
        dmem_we   = (ins == InsSw);
        if (bus.dmem_ack) begin
          if (ins == InsSw) begin
            pc_we   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else begin
          req_wait = 1'b1;
        end
      end

      StWb: begin
        alu_ctrl  = ins_alu;
        alub_ctrl = ins_alub;
        ext_ctrl  = ins_ext;
        grf_we    = 1'b1;
        pc_we     = 1'b1;
        wa_ctrl   = (ins inside {InsAddu, InsSubu}) ? 2'b01 : 2'b00;
        wd_ctrl   = (ins == InsLw) ? 2'b01 : 2'b00;
        state_d   = StFetch;
      end

      StTrap: ;

      default: state_d = StFetch;
    endcase

    // A same-cycle ack clears req_wait, so it always beats the timeout.
    if (TimeoutEn && req_wait && (wait_q == WaitLast)) begin
      state_d     = StTrap;
      set_bus_err = 1'b1;
    end
  end

  // Counts consecutive unacknowledged request cycles; zero whenever no request is pending.
  always_comb begin
    wait_d = '0;
    if (req_wait) begin
      wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
      if (pc_we) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.imem_req  = imem_req;
  assign bus.dmem_req  = dmem_req;
  assign bus.dmem_we   = dmem_we;
  assign bus.ir_we     = ir_we;
  assign bus.pc_we     = pc_we;
  assign bus.grf_we    = grf_we;
  assign bus.wa_ctrl   = wa_ctrl;
  assign bus.wd_ctrl   = wd_ctrl;
  assign bus.alu_ctrl  = alu_ctrl;
  assign bus.alub_ctrl = alub_ctrl;
  assign bus.ext_ctrl  = ext_ctrl;
  assign bus.jump_ctrl = jump_ctrl;
  assign bus.state     = state_q;
  assign bus.illegal   = illegal_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized instruction mixes
// checked cycle by cycle against a per-instruction behavioural model.
module tb_multicycle_ctrl;
  localparam int unsigned AckTimeout = 4;
  localparam int unsigned CntW       = 4;
  localparam int NOP = 0, ADDU = 1, SUBU = 2, JR = 3, ORI = 4, LW = 5, SW = 6, BEQ = 7,
                 LUI = 8, JAL = 9, ILL = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CntW)) bus ();
  multicycle_ctrl #(.ACK_TIMEOUT(AckTimeout), .CNT_W(CntW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, grf_we;
    logic [1:0] wa, wd, alu;
    logic       alub, ext;
    logic [1:0] jump;
    logic [2:0] st;
  } ctl_t;

  int checks = 0;
  int errors = 0;
  int ret_m  = 0;

  function automatic ctl_t blank(input logic [2:0] st);
    ctl_t c = '0;
    c.st = st;
    return c;
  endfunction

  function automatic ctl_t observe();
    ctl_t c;
    c.imem_req = bus.imem_req;  c.dmem_req = bus.dmem_req; c.dmem_we = bus.dmem_we;
    c.ir_we    = bus.ir_we;     c.pc_we    = bus.pc_we;    c.grf_we  = bus.grf_we;
    c.wa       = bus.wa_ctrl;   c.wd       = bus.wd_ctrl;  c.alu     = bus.alu_ctrl;
    c.alub     = bus.alub_ctrl; c.ext      = bus.ext_ctrl; c.jump    = bus.jump_ctrl;
    c.st       = bus.state;
    return c;
  endfunction

  // ALU selects each instruction class needs while its operands are in flight.
  function automatic ctl_t with_alu(input int id, input ctl_t c0);
    ctl_t c = c0;
    case (id)
      SUBU, BEQ: c.alu = 2'b01;
      ORI:       begin c.alu = 2'b10; c.alub = 1'b1; end
      LUI:       begin c.alu = 2'b11; c.alub = 1'b1; end
      LW, SW:    begin c.alub = 1'b1; c.ext = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic check_ctl(input string tag, input ctl_t exp);
    ctl_t obs;
    @(negedge clk);
    obs = observe();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_code(input int id);
    bus.funct = 6'($urandom);
    case (id)
      NOP:  begin bus.opcode = 6'b000000; bus.funct = 6'b000000; end
      ADDU: begin bus.opcode = 6'b000000; bus.funct = 6'b100001; end
      SUBU: begin bus.opcode = 6'b000000; bus.funct = 6'b100011; end
      JR:   begin bus.opcode = 6'b000000; bus.funct = 6'b001000; end
      ORI:  bus.opcode = 6'b001101;
      LW:   bus.opcode = 6'b100011;
      SW:   bus.opcode = 6'b101011;
      BEQ:  bus.opcode = 6'b000100;
      LUI:  bus.opcode = 6'b001111;
      JAL:  bus.opcode = 6'b000011;
      default: begin
        if ($urandom_range(0, 1) == 0) bus.opcode = 6'b111111;
        else begin bus.opcode = 6'b000000; bus.funct = 6'b100000; end
      end
    endcase
  endtask

  task automatic stray_acks();
    bus.imem_ack = 1'($urandom);
    bus.dmem_ack = 1'($urandom);
  endtask

  task automatic retire();
    ret_m = (ret_m + 1) % (1 << CntW);
    check_val("retired", 32'(bus.retired), 32'(ret_m));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ret_m = 0;
    check_val("rst_retired", 32'(bus.retired), 0);
    check_val("rst_illegal", 32'(bus.illegal), 0);
    check_val("rst_bus_err", 32'(bus.bus_err), 0);
  endtask

  // One whole instruction: idly/ddly are the wait cycles before imem/dmem ack.
  task automatic run_instr(input int id, input int idly, input int ddly, input logic az);
    ctl_t e;
    set_code(id);
    bus.alu_zero = az;
    for (int k = 0; k <= idly; k++) begin
      bus.imem_ack = (k == idly);
      bus.dmem_ack = 1'($urandom);
      e = blank(3'd0); e.imem_req = 1'b1; e.ir_we = (k == idly);
      check_ctl("fetch", e);
    end
    stray_acks();
    e = blank(3'd1);
    e.ext = (id == LW || id == SW || id == BEQ);
    if (id == NOP) e.pc_we = 1'b1;
    check_ctl("decode", e);
    if (id == NOP) begin retire(); return; end
    if (id == ILL) return;
    stray_acks();
    e = with_alu(id, blank(3'd2));
    case (id)
      BEQ: begin e.pc_we = 1'b1; e.jump = {1'b0, az}; end
      JAL: begin e.grf_we = 1'b1; e.wa = 2'b10; e.wd = 2'b10; e.pc_we = 1'b1; e.jump = 2'b10; end
      JR:  begin e.pc_we = 1'b1; e.jump = 2'b11; end
      default: ;
    endcase
    check_ctl("exec", e);
    if (id == BEQ || id == JAL || id == JR) begin retire(); return; end
    if (id == LW || id == SW) begin
      for (int k = 0; k <= ddly; k++) begin
        bus.dmem_ack = (k == ddly);
        bus.imem_ack = 1'($urandom);
        e = with_alu(id, blank(3'd3));
        e.dmem_req = 1'b1; e.dmem_we = (id == SW); e.pc_we = (id == SW && k == ddly);
        check_ctl("mem", e);
      end
      if (id == SW) begin retire(); return; end
    end
    stray_acks();
    e = with_alu(id, blank(3'd4));
    e.grf_we = 1'b1; e.pc_we = 1'b1;
    e.wa = (id == ADDU || id == SUBU) ? 2'b01 : 2'b00;
    e.wd = (id == LW) ? 2'b01 : 2'b00;
    check_ctl("wb", e);
    retire();
  endtask

  initial begin
    ctl_t e;
    bus.opcode = '0; bus.funct = '0; bus.alu_zero = 1'b0;
    do_reset();

    run_instr(ADDU, 0, 0, 1'b0);
    run_instr(LW, 0, 3, 1'b0);
    check_val("lw_bus_err", 32'(bus.bus_err), 0);
    run_instr(BEQ, 0, 0, 1'b1);
    run_instr(BEQ, 0, 0, 1'b0);
    run_instr(JAL, 1, 0, 1'b0);
    run_instr(JR, 2, 0, 1'b1);
    run_instr(SW, 0, 2, 1'b0);

    // Illegal instruction: absorbing trap, nothing retires.
    run_instr(ILL, 0, 0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      stray_acks();
      check_ctl("ill_trap", blank(3'd5));
    end
    check_val("ill_flag", 32'(bus.illegal), 1);
    check_val("ill_bus_err", 32'(bus.bus_err), 0);
    check_val("ill_retired", 32'(bus.retired), 32'(ret_m));

    // Instruction fetch timeout.
    do_reset();
    set_code(NOP);
    for (int k = 0; k < int'(AckTimeout); k++) begin
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'($urandom);
      e = blank(3'd0); e.imem_req = 1'b1;
      check_ctl("ito_fetch", e);
    end
    for (int k = 0; k < 3; k++) begin
      stray_acks();
      check_ctl("ito_trap", blank(3'd5));
    end
    check_val("ito_bus_err", 32'(bus.bus_err), 1);
    check_val("ito_illegal", 32'(bus.illegal), 0);

    // Ack on the last allowed cycle wins over the timeout.
    do_reset();
    run_instr(NOP, int'(AckTimeout) - 1, 0, 1'b0);
    run_instr(LW, int'(AckTimeout) - 1, int'(AckTimeout) - 1, 1'b0);
    check_val("late_ack_bus_err", 32'(bus.bus_err), 0);

    // Data memory timeout during a load.
    do_reset();
    run_instr(ORI, 0, 0, 1'b0);
    set_code(LW);
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b0;
    e = blank(3'd0); e.imem_req = 1'b1; e.ir_we = 1'b1;
    check_ctl("dto_fetch", e);
    e = blank(3'd1); e.ext = 1'b1;
    check_ctl("dto_decode", e);
    check_ctl("dto_exec", with_alu(LW, blank(3'd2)));
    for (int k = 0; k < int'(AckTimeout); k++) begin
      bus.dmem_ack = 1'b0;
      e = with_alu(LW, blank(3'd3)); e.dmem_req = 1'b1;
      check_ctl("dto_mem", e);
    end
    check_ctl("dto_trap", blank(3'd5));
    check_val("dto_bus_err", 32'(bus.bus_err), 1);
    check_val("dto_retired", 32'(bus.retired), 32'(ret_m));

    // Retired counter wraps at 2^CntW.
    do_reset();
    for (int k = 0; k < 16; k++) run_instr(NOP, 0, 0, 1'b0);
    check_val("wrap_retired", 32'(bus.retired), 0);

    // Reset in the middle of a store's memory phase.
    run_instr(NOP, 0, 0, 1'b0);
    set_code(SW);
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b0;
    e = blank(3'd0); e.imem_req = 1'b1; e.ir_we = 1'b1;
    check_ctl("rsw_fetch", e);
    e = blank(3'd1); e.ext = 1'b1;
    check_ctl("rsw_decode", e);
    check_ctl("rsw_exec", with_alu(SW, blank(3'd2)));
    bus.imem_ack = 1'b0;
    reset = 1'b1;
    e = with_alu(SW, blank(3'd3)); e.dmem_req = 1'b1; e.dmem_we = 1'b1;
    check_ctl("rsw_mem", e);
    reset = 1'b0;
    ret_m = 0;
    check_val("rsw_retired", 32'(bus.retired), 0);
    e = blank(3'd0); e.imem_req = 1'b1;
    check_ctl("rsw_post", e);

    // Randomized legal instruction mix.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      run_instr($urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom));
    end
    check_val("rand_illegal", 32'(bus.illegal), 0);
    check_val("rand_bus_err", 32'(bus.bus_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
